sw_event_encoder: RTL

- Parametrised switch-event front end for the lab board.
- Synchronises and debounces N_SW slide switches and detects changes in both directions.
- Queues changes in a pending mask and presents them one at a time (index + new level) on a valid/ready interface to the downstream editor/display logic.
- Handles simultaneous and bouncing changes; reports both on and off transitions.

---
 rtl/sw_evt_pkg.sv | 26 ++
 rtl/sw_debounce.sv | 59 +++++
 rtl/sw_event_encoder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sw_evt_pkg.sv
// Shared helpers for the switch-event front end: debounce counter sizing,
// lowest-set-bit priority encoder and reset constants.
package sw_evt_pkg;

  localparam logic        RST_LEVEL = 1'b0;
  localparam logic [15:0] RST_COUNT = 16'h0000;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // Width of a counter that must reach DB_CYCLES-1; never narrower than 1 bit.
  function automatic int db_cnt_width(input int db);
    int w;
    w = $clog2(db);
    return (w < 1) ? 1 : w;
  endfunction

  // Index of the lowest set bit of v (0 when v is all zeros).
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] result;
    result = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) result = 5'(i);
    end
    return result;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch: synchroniser chain, stability counter, accepted level and a
// one-cycle strobe on the cycle the accepted level changes.
module sw_debounce
  import sw_evt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic stable_o,
  output logic chg_o
);

  localparam int             CW       = db_cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   syncOut;
  logic                   differ;
  logic                   chg;

  assign syncOut  = sync_q[SYNC_STAGES-1];
  assign differ   = syncOut ^ stable_q;
  assign chg      = differ && (cnt_q == CNT_LAST);
  assign stable_o = stable_q;
  assign chg_o    = chg;

  // Next-state for the debounce counter and the accepted level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (chg) begin
      stable_d = syncOut;
      cnt_d    = '0;
    end else if (differ) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  // Shift the raw level through the synchroniser and register debounce state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= RST_LEVEL;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sw_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sw_event_encoder.sv
// Switch-event encoder: debounces N_SW switches, collects accepted changes
// in a pending mask and hands them out lowest index first on valid/ready.
// Optional build macro SW_EVENT_ENCODER_COUNT_EN adds a saturating transfer
// counter (evt_count) and a sticky lost-change-pair flag (evt_drop).
module sw_event_encoder
  import sw_evt_pkg::*;
#(
  parameter  int N_SW        = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int DB_CYCLES   = 16,
  localparam int IDX_W       = $clog2(N_SW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  sw,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  output logic             evt_level
`ifdef SW_EVENT_ENCODER_COUNT_EN
  ,
  output logic [15:0]      evt_count,
  output logic             evt_drop
`endif
);

  logic [N_SW-1:0]  stable;
  logic [N_SW-1:0]  chg;
  logic [N_SW-1:0]  pend_q, pend_d;
  logic [N_SW-1:0]  loadMask;
  logic             evt_valid_q, evt_valid_d;
  logic [IDX_W-1:0] evt_idx_q, evt_idx_d;
  logic             evt_level_q, evt_level_d;
  logic [31:0]      pendWide;
  logic [4:0]       lowIdxFull;
  logic [IDX_W-1:0] lowIdx;
  logic             doLoad;

  // One debouncer per switch.
  for (genvar g = 0; g < N_SW; g++) begin : g_db
    sw_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .sw_i    (sw[g]),
      .stable_o(stable[g]),
      .chg_o   (chg[g])
    );
  end

  // Arbitration, pending-mask update and output-register next state.
  always_comb begin
    pendWide            = '0;
    pendWide[N_SW-1:0]  = pend_q;
    lowIdxFull          = lowest_set(pendWide);
    lowIdx              = lowIdxFull[IDX_W-1:0];
    doLoad              = (!evt_valid_q || evt_ready) && (|pend_q);
    loadMask            = doLoad ? (N_SW'(1) << lowIdx) : '0;
    pend_d              = (pend_q & ~loadMask) ^ chg;
    evt_valid_d         = evt_valid_q;
    evt_idx_d           = evt_idx_q;
    evt_level_d         = evt_level_q;
    if (doLoad) begin
      evt_valid_d = 1'b1;
      evt_idx_d   = lowIdx;
      evt_level_d = stable[lowIdx];
    end else if (evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  // Register the pending mask and the presented event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_idx_q   <= '0;
      evt_level_q <= RST_LEVEL;
    end else begin
      pend_q      <= pend_d;
      evt_valid_q <= evt_valid_d;
      evt_idx_q   <= evt_idx_d;
      evt_level_q <= evt_level_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_idx   = evt_idx_q;
  assign evt_level = evt_level_q;

`ifdef SW_EVENT_ENCODER_COUNT_EN
  logic [15:0] count_q, count_d;
  logic        drop_q, drop_d;

  // Count completed transfers (saturating) and latch any cancelled change pair.
  always_comb begin
    count_d = count_q;
    if (evt_valid_q && evt_ready && (count_q != COUNT_MAX)) begin
      count_d = count_q + 16'd1;
    end
    drop_d = drop_q | (|(chg & pend_q & ~loadMask));
  end

  // Register the statistics outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_COUNT;
      drop_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign evt_count = count_q;
  assign evt_drop  = drop_q;
`endif

endmodule
